// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package dmem_pkg;

    localparam int WORD_W      = 32;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_W register storage, synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; a write is taken on every cycle wr_en is high.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_dat,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_dat
);

    // Contents are deliberately left unreset; software owns initialisation.
    logic [WORD_W-1:0] mem_q [DEPTH];

    // Store port: one word per cycle when enabled.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder for the core MEM stage; optional DMEM_ALIGN_CHECK_EN flags misaligned accesses.
// Latency: RespValid pulses LATENCY cycles after the accept edge; next accept possible one cycle later.
// Backpressure: ReqReady only in IDLE; StallM holds the pipeline while a request waits or is in flight.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 64
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [31:0]       ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic              ReqReady,
    output logic              StallM,
    output logic              RespValid,
    output logic [31:0]       RespRData,
    output logic              RespErr
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              misalign;
    logic              wr_en;
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] rd_dat;
    logic              addr_unused;

    // Upper address bits wrap away; the byte offset only matters with the alignment check.
    assign word_idx    = ReqAddr[AW+1:2];
    assign addr_unused = ^{ReqAddr[31:AW+2], ReqAddr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (ReqAddr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign accept = ReqValid && (state_q == IDLE);
    assign wr_en  = accept && ReqWrite && !misalign;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .Clk    (Clk),
        .wr_en  (wr_en),
        .wr_idx (word_idx),
        .wr_dat (ReqWData),
        .rd_idx (word_idx),
        .rd_dat (rd_dat)
    );

    // Next-state: capture the response at accept, count down WAIT, one RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Load data is sampled now, so later traffic cannot disturb it.
                    rdata_d = (ReqWrite || misalign) ? '0 : rd_dat;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q, err_d;

    // Error flag is latched with the request and only shown during RESP.
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = misalign;
        end
    end

    // Error flag register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign RespErr = (state_q == RESP) && err_q;
`else
    assign RespErr = 1'b0;
`endif

    assign ReqReady  = (state_q == IDLE);
    assign StallM    = ((state_q == IDLE) && ReqValid) || (state_q == WAIT);
    assign RespValid = (state_q == RESP);
    assign RespRData = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 4) against a word-array reference model.
// Latency: each transaction is checked cycle by cycle from accept through the return to IDLE.
// Backpressure: held, dropped and toggling ReqValid patterns exercise the single-outstanding rule.
module tb_dmem_responder;

    localparam int N     = 3;
    localparam int DEPTH = 64;
    localparam int LATS [N] = '{2, 1, 4};

    logic             Clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_write;
    logic [31:0]      req_addr  [N];
    logic [31:0]      req_wdata [N];
    logic [N-1:0]     req_ready;
    logic [N-1:0]     stall_m;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_err;
    logic [31:0]      resp_rdata [N];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference storage: one plain word array per instance.
    logic [31:0] mem_m [N][DEPTH];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .LATENCY (LATS[g]),
            .DEPTH   (DEPTH)
        ) u_dut (
            .Clk       (Clk),
            .reset     (reset),
            .ReqValid  (req_valid[g]),
            .ReqWrite  (req_write[g]),
            .ReqAddr   (req_addr[g]),
            .ReqWData  (req_wdata[g]),
            .ReqReady  (req_ready[g]),
            .StallM    (stall_m[g]),
            .RespValid (resp_valid[g]),
            .RespRData (resp_rdata[g]),
            .RespErr   (resp_err[g])
        );
    end

    task automatic check1(input string tag, input int k, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    function automatic bit is_misaligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a % (DEPTH * 4)) / 4);
    endfunction

    // One request on instance k. Entered right after a rising edge with the DUT idle;
    // returns right after the edge that brings it back to idle.
    // mode 0: drop ReqValid after accept; 1: toggle junk requests while waiting; 2: hold it.
    task automatic txn(input int k, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int mode);
        int          lat;
        int          idx;
        bit          bad;
        logic [31:0] exp_d;
        lat   = LATS[k];
        idx   = word_of(addr);
        bad   = is_misaligned(addr);
        exp_d = (wr || bad) ? 32'h0 : mem_m[k][idx];
        #1;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        #1;
        check1("ready_idle", k, req_ready[k], 1'b1);
        check1("stall_req", k, stall_m[k], 1'b1);
        check1("valid_idle", k, resp_valid[k], 1'b0);
        @(posedge Clk);
        if (wr && !bad) mem_m[k][idx] = wdata;
        for (int e = 1; e <= lat; e++) begin
            #1;
            if (mode == 1 && e < lat) begin
                req_valid[k] = 1'($urandom_range(1, 0));
                req_write[k] = 1'b1;
                req_addr[k]  = $urandom;
                req_wdata[k] = $urandom;
            end else if (mode != 2) begin
                req_valid[k] = 1'b0;
            end
            #1;
            check1("resp_valid", k, resp_valid[k], e == lat);
            check1("ready_busy", k, req_ready[k], 1'b0);
            check1("stall_busy", k, stall_m[k], e < lat);
            check32("rdata", k, resp_rdata[k], exp_d);
            check1("resp_err", k, resp_err[k], (e == lat) && bad);
            @(posedge Clk);
        end
    endtask

    // One quiet idle cycle on instance k.
    task automatic idle_check(input int k);
        #1;
        req_valid[k] = 1'b0;
        #1;
        check1("ready_quiet", k, req_ready[k], 1'b1);
        check1("stall_quiet", k, stall_m[k], 1'b0);
        check1("valid_quiet", k, resp_valid[k], 1'b0);
        check1("err_quiet", k, resp_err[k], 1'b0);
        @(posedge Clk);
    endtask

    // Accept a request, then reset during the first WAIT cycle.
    task automatic reset_mid(input int k, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
        #1;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        @(posedge Clk);
        if (wr && !is_misaligned(addr)) mem_m[k][word_of(addr)] = wdata;
        #1;
        req_valid[k] = 1'b0;
        reset        = 1'b1;
        #1;
        check1("rst_ready", k, req_ready[k], 1'b1);
        check1("rst_valid", k, resp_valid[k], 1'b0);
        check32("rst_rdata", k, resp_rdata[k], 32'h0);
        check1("rst_stall", k, stall_m[k], 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < LATS[k] + 2; c++) begin
            #1;
            check1("rst_no_pulse", k, resp_valid[k], 1'b0);
            check1("rst_ready_after", k, req_ready[k], 1'b1);
            @(posedge Clk);
        end
    endtask

    initial begin
        int          k;
        int          mode;
        logic [31:0] a;
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end

        // Reset state on every instance.
        #2;
        for (int i = 0; i < N; i++) begin
            check1("reset_ready", i, req_ready[i], 1'b1);
            check1("reset_valid", i, resp_valid[i], 1'b0);
            check1("reset_stall", i, stall_m[i], 1'b0);
            check1("reset_err", i, resp_err[i], 1'b0);
            check32("reset_rdata", i, resp_rdata[i], 32'h0);
        end
        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b0;
        @(posedge Clk);

        // Fill every word through aliased addresses so later loads have known data.
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < DEPTH; w++) begin
                a = ($urandom & 32'hFFFF_FF00) | 32'(w * 4);
                txn(i, 1'b1, a, $urandom, 0);
            end
        end

        // Store then load back on LATENCY=2.
        txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 0);

        // Address wrap modulo DEPTH*4.
        txn(0, 1'b1, 32'h0000_0100, 32'h1234_5678, 0);
        txn(0, 1'b0, 32'h0000_0000, 32'h0, 0);

        // Misaligned store followed by aligned load of the same word.
        txn(0, 1'b0, 32'h0000_0020, 32'h0, 0);
        txn(0, 1'b1, 32'h0000_0022, 32'hAAAA_5555, 0);
        txn(0, 1'b0, 32'h0000_0020, 32'h0, 0);

        // LATENCY=1 with ReqValid held: one accept every two cycles.
        for (int r = 0; r < 4; r++) txn(1, 1'b0, 32'h0000_0040 + 32'(r * 4), 32'h0, 2);
        idle_check(1);

        // LATENCY=4 with junk requests toggling during WAIT.
        for (int r = 0; r < 6; r++) txn(2, 1'(r % 2), $urandom, $urandom, 1);
        idle_check(2);

        // Reset during WAIT of a load, then a normal request.
        reset_mid(0, 1'b0, 32'h0000_0030, 32'h0);
        txn(0, 1'b0, 32'h0000_0030, 32'h0, 0);
        // Reset during WAIT of a store: the committed word survives.
        reset_mid(2, 1'b1, 32'h0000_0044, 32'hC0FF_EE01);
        txn(2, 1'b0, 32'h0000_0044, 32'h0, 0);

        // Random mix across all instances.
        for (int r = 0; r < 60; r++) begin
            k    = int'($urandom_range(N - 1, 0));
            mode = int'($urandom_range(2, 0));
            txn(k, 1'($urandom_range(1, 0)), $urandom, $urandom, mode);
            if (mode == 2) idle_check(k);
        end
        for (int i = 0; i < N; i++) idle_check(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
